exc_ctrl: RTL and testbench
===========================

EXC_CTRL -- requirements
Module: exc_ctrl

Interface
REQ-001 Parameter EXC_VECTOR, 32'h0000_0020: general exception entry address.
REQ-002 Parameter ERET_CODE, 5'h1F: internal code marking ERET; never written to Cause.
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 excepttype_i  in  32  MEM-stage exception flags: bit8 syscall, bit9 invalid inst, bit10 trap, bit11 overflow, bit12 eret.
REQ-006 inst_valid_i  in  1  MEM-stage instruction valid.
REQ-007 current_inst_addr_i  in  32  MEM-stage instruction PC.
REQ-008 is_in_delayslot_i  in  1  MEM-stage instruction sits in a delay slot.
REQ-009 cp0_status_i, cp0_cause_i, cp0_epc_i  in  32 each  live CP0 Status/Cause/EPC.
REQ-010 stall_o  out  1  pipeline hold while the sequence runs.
REQ-011 flush_o  out  1  one-cycle pipeline flush.
REQ-012 new_pc_o  out  32  redirect target, valid with flush_o.
REQ-013 cp0_we_o  out  1; cp0_waddr_o  out  5; cp0_data_o  out  32: CP0 write port.
REQ-014 cause_we_o  out  1; cause_excode_o  out  5; cause_bd_o  out  1: CP0 hardware Cause-update port.
REQ-015 excepttype_o  out  5  code of the event in progress, 0 when idle.

Function
REQ-016 Interrupt pending SHALL be (cause[15:8] & status[15:8]) != 0 && status[0]==1 && status[1]==0.
REQ-017 Priority SHALL be interrupt (code 0x00) > syscall (0x08) > invalid (0x0A) > trap (0x0D) > overflow (0x0C) > eret; interrupt requires inst_valid_i.
REQ-018 An event SHALL be accepted only in IDLE with inst_valid_i=1; inputs in other states are ignored.
REQ-019 States SHALL be IDLE, WR_EPC, WR_STATUS, REDIRECT; exception path IDLE->WR_EPC->WR_STATUS->REDIRECT->IDLE; ERET path IDLE->WR_STATUS->REDIRECT->IDLE.
REQ-020 On acceptance, code, PC, delay-slot flag, status and epc SHALL be snapshotted; later input changes do not affect the sequence.
REQ-021 WR_EPC: cp0_we_o=1, waddr=14, data = PC-4 if delay slot else PC; cause_we_o=1 with snapshotted code and BD.
REQ-022 WR_STATUS: cp0_we_o=1, waddr=12, data = status snapshot with bit1 set (exception) or cleared (ERET).
REQ-023 REDIRECT: flush_o=1 for exactly one cycle, new_pc_o = EXC_VECTOR (exception) or epc snapshot (ERET).
REQ-024 stall_o SHALL be 1 in WR_EPC, WR_STATUS and REDIRECT, 0 in IDLE.
REQ-025 All outputs SHALL be registered; latency from accepting edge to flush_o is 3 cycles (exception) or 2 cycles (ERET).
REQ-026 PC-4 SHALL wrap modulo 2^32 (PC 0 gives 32'hFFFF_FFFC).
REQ-027 Interrupt coincident with an instruction exception: interrupt wins, EPC is that instruction's PC.

Reset
REQ-028 Reset SHALL force IDLE and drive every output and snapshot to 0, including mid-sequence; no partial CP0 write completes after reset.

Structure
REQ-029 CP0 register addresses (12, 13, 14), ExcCode values and state encodings SHALL live in the shared define package.
REQ-030 Priority selection SHALL be a combinational sub-module exc_prio (flags, status, cause -> code, valid).

Verification
REQ-031 Syscall at PC 0x100, no delay slot, status 0x1000_0001 -> EPC write 0x100, cause code 0x08 BD 0, status write 0x1000_0003, flush with new_pc 0x20 three cycles later.
REQ-032 Overflow at PC 0x204, delay slot -> EPC 0x200, BD 1, code 0x0C.
REQ-033 ERET with epc 0x400, status 0x1000_0003 -> single status write 0x1000_0001, flush with new_pc 0x400 two cycles later; no EPC write.
REQ-034 cause[10]=1, status 0x0000_0401, syscall flag set -> code 0x00 wins; with status bit1=1 instead -> syscall taken.
REQ-035 Second syscall presented while in WR_STATUS -> ignored, exactly one flush.
REQ-036 rst asserted during WR_EPC -> all outputs 0 immediately, IDLE on release, no further CP0 writes.

Source files
------------

// File: rtl/exc_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception sequencer:
// CP0 addresses, ExcCodes, FSM states and the registered output bundle.
package exc_ctrl_pkg;

  localparam logic [4:0] CP0_STATUS = 5'd12;
  localparam logic [4:0] CP0_CAUSE  = 5'd13;
  localparam logic [4:0] CP0_EPC    = 5'd14;

  localparam logic [4:0] EXC_INT = 5'h00;
  localparam logic [4:0] EXC_SYS = 5'h08;
  localparam logic [4:0] EXC_RI  = 5'h0A;
  localparam logic [4:0] EXC_TR  = 5'h0D;
  localparam logic [4:0] EXC_OV  = 5'h0C;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WR_EPC    = 2'd1,
    WR_STATUS = 2'd2,
    REDIRECT  = 2'd3
  } exc_state_e;

  typedef struct packed {
    logic [4:0]  code;
    logic [31:0] pc;
    logic        bd;
    logic [31:0] status;
    logic [31:0] epc;
  } exc_snap_t;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        cp0_we;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_data;
    logic        cause_we;
    logic [4:0]  cause_excode;
    logic        cause_bd;
    logic [4:0]  excepttype;
  } exc_out_t;

  // Delay-slot instructions restart at the branch; wraps mod 2^32.
  function automatic logic [31:0] epc_value(
    input logic [31:0] pc,
    input logic        bd
  );
    return bd ? pc - 32'd4 : pc;
  endfunction

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 side bundle of the exception controller.
// master: the controller; slave: pipeline and CP0 around it.
interface exc_ctrl_if;
  logic [31:0] excepttype_i;
  logic        inst_valid_i;
  logic [31:0] current_inst_addr_i;
  logic        is_in_delayslot_i;
  logic [31:0] cp0_status_i;
  logic [31:0] cp0_cause_i;
  logic [31:0] cp0_epc_i;
  logic        stall_o;
  logic        flush_o;
  logic [31:0] new_pc_o;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_data_o;
  logic        cause_we_o;
  logic [4:0]  cause_excode_o;
  logic        cause_bd_o;
  logic [4:0]  excepttype_o;

  modport master (
    input  excepttype_i, inst_valid_i,
    input  current_inst_addr_i,
    input  is_in_delayslot_i,
    input  cp0_status_i, cp0_cause_i,
    input  cp0_epc_i,
    output stall_o, flush_o, new_pc_o,
    output cp0_we_o, cp0_waddr_o,
    output cp0_data_o,
    output cause_we_o, cause_excode_o,
    output cause_bd_o, excepttype_o
  );

  modport slave (
    output excepttype_i, inst_valid_i,
    output current_inst_addr_i,
    output is_in_delayslot_i,
    output cp0_status_i, cp0_cause_i,
    output cp0_epc_i,
    input  stall_o, flush_o, new_pc_o,
    input  cp0_we_o, cp0_waddr_o,
    input  cp0_data_o,
    input  cause_we_o, cause_excode_o,
    input  cause_bd_o, excepttype_o
  );
endinterface

// File: rtl/exc_ctrl_prio.sv
// Combinational event priority: interrupt > syscall > invalid
// > trap > overflow > eret.
module exc_prio
  import exc_ctrl_pkg::*;
#(
  parameter logic [4:0] ERET_CODE = 5'h1F
) (
  input  logic [4:0] flags_i,
  input  logic [7:0] ip_i,
  input  logic [7:0] im_i,
  input  logic       ie_i,
  input  logic       exl_i,
  output logic [4:0] code_o,
  output logic       valid_o
);

  logic       irq;
  logic [5:0] req;
  logic [5:0] gnt;

  assign irq = (|(ip_i & im_i)) & ie_i & ~exl_i;
  assign req = {flags_i, irq};
  // Isolate the lowest set bit so the case items are one-hot.
  assign gnt = req & (~req + 6'd1);

  always_comb begin
    code_o  = '0;
    valid_o = 1'b1;
    unique case (1'b1)
      gnt[0]:  code_o = EXC_INT;
      gnt[1]:  code_o = EXC_SYS;
      gnt[2]:  code_o = EXC_RI;
      gnt[3]:  code_o = EXC_TR;
      gnt[4]:  code_o = EXC_OV;
      gnt[5]:  code_o = ERET_CODE;
      default: valid_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/ERET sequencer: snapshots the MEM-stage event, writes
// EPC/Cause and Status over successive cycles, then flushes.
module exc_ctrl
  import exc_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [4:0]  ERET_CODE  = 5'h1F
) (
  input  logic       clk,
  input  logic       rst,
  exc_ctrl_if.master bus
);

  exc_state_e state_q, state_d;
  exc_snap_t  snap_q, snap_d;
  exc_out_t   out_q, out_d;
  logic [4:0] prio_code;
  logic       prio_valid;
  logic       snap_eret;

  exc_prio #(.ERET_CODE(ERET_CODE)) u_prio (
    .flags_i (bus.excepttype_i[12:8]),
    .ip_i    (bus.cp0_cause_i[15:8]),
    .im_i    (bus.cp0_status_i[15:8]),
    .ie_i    (bus.cp0_status_i[0]),
    .exl_i   (bus.cp0_status_i[1]),
    .code_o  (prio_code),
    .valid_o (prio_valid)
  );

  assign snap_eret = (snap_q.code == ERET_CODE);

  // Outputs are computed for the state being entered and registered.
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    out_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.inst_valid_i && prio_valid) begin
          snap_d.code   = prio_code;
          snap_d.pc     = bus.current_inst_addr_i;
          snap_d.bd     = bus.is_in_delayslot_i;
          snap_d.status = bus.cp0_status_i;
          snap_d.epc    = bus.cp0_epc_i;
          out_d.stall      = 1'b1;
          out_d.cp0_we     = 1'b1;
          out_d.excepttype = prio_code;
          if (prio_code == ERET_CODE) begin
            state_d         = WR_STATUS;
            out_d.cp0_waddr = CP0_STATUS;
            out_d.cp0_data  = bus.cp0_status_i
                              & ~32'h2;
          end else begin
            state_d         = WR_EPC;
            out_d.cp0_waddr = CP0_EPC;
            out_d.cp0_data  = epc_value(
              bus.current_inst_addr_i,
              bus.is_in_delayslot_i);
            out_d.cause_we     = 1'b1;
            out_d.cause_excode = prio_code;
            out_d.cause_bd     = bus.is_in_delayslot_i;
          end
        end
      end
      WR_EPC: begin
        state_d          = WR_STATUS;
        out_d.stall      = 1'b1;
        out_d.excepttype = snap_q.code;
        out_d.cp0_we     = 1'b1;
        out_d.cp0_waddr  = CP0_STATUS;
        out_d.cp0_data   = snap_q.status | 32'h2;
      end
      WR_STATUS: begin
        state_d          = REDIRECT;
        out_d.stall      = 1'b1;
        out_d.flush      = 1'b1;
        out_d.excepttype = snap_q.code;
        out_d.new_pc     = snap_eret ? snap_q.epc
                                     : EXC_VECTOR;
      end
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      snap_q  <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      out_q   <= out_d;
    end
  end

  assign bus.stall_o        = out_q.stall;
  assign bus.flush_o        = out_q.flush;
  assign bus.new_pc_o       = out_q.new_pc;
  assign bus.cp0_we_o       = out_q.cp0_we;
  assign bus.cp0_waddr_o    = out_q.cp0_waddr;
  assign bus.cp0_data_o     = out_q.cp0_data;
  assign bus.cause_we_o     = out_q.cause_we;
  assign bus.cause_excode_o = out_q.cause_excode;
  assign bus.cause_bd_o     = out_q.cause_bd;
  assign bus.excepttype_o   = out_q.excepttype;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl: per-cycle expected outputs are
// queued at stimulus time and checked on every falling edge.
module tb_exc_ctrl;

  typedef struct packed {
    logic        stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] data;
    logic        cause_we;
    logic [4:0]  excode;
    logic        bd;
    logic [4:0]  exct;
  } obs_t;

  localparam logic [4:0] ERET = 5'h1F;

  logic  clk = 1'b0;
  logic  rst_n = 1'b1;
  int    tests = 0;
  int    fails = 0;
  string cur_tag = "reset";
  obs_t  sb[$];

  exc_ctrl_if bus ();

  exc_ctrl #(
    .EXC_VECTOR (32'h0000_0020),
    .ERET_CODE  (5'h1F)
  ) u_dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  function automatic obs_t sample();
    obs_t o;
    o.stall    = bus.stall_o;
    o.flush    = bus.flush_o;
    o.new_pc   = bus.new_pc_o;
    o.we       = bus.cp0_we_o;
    o.waddr    = bus.cp0_waddr_o;
    o.data     = bus.cp0_data_o;
    o.cause_we = bus.cause_we_o;
    o.excode   = bus.cause_excode_o;
    o.bd       = bus.cause_bd_o;
    o.exct     = bus.excepttype_o;
    return o;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t exp_o, got;
      exp_o = sb.pop_front();
      got   = sample();
      tests++;
      assert (got === exp_o) else begin
        fails++;
        $error("FAIL %s got=%h exp=%h",
               cur_tag, got, exp_o);
      end
    end
  end

  task automatic push_idle(input int n);
    repeat (n) sb.push_back('0);
  endtask

  task automatic push_seq(
    input logic [4:0]  code,
    input logic [31:0] pc,
    input logic        bd,
    input logic [31:0] status,
    input logic [31:0] epc
  );
    obs_t e;
    if (code != ERET) begin
      e = '0;
      e.stall = 1'b1; e.we = 1'b1;
      e.waddr = 5'd14;
      e.data  = bd ? pc - 32'd4 : pc;
      e.cause_we = 1'b1; e.excode = code;
      e.bd = bd; e.exct = code;
      sb.push_back(e);
    end
    e = '0;
    e.stall = 1'b1; e.we = 1'b1;
    e.waddr = 5'd12; e.exct = code;
    e.data  = (code == ERET) ? status & ~32'h2
                             : status | 32'h2;
    sb.push_back(e);
    e = '0;
    e.stall = 1'b1; e.flush = 1'b1;
    e.exct  = code;
    e.new_pc = (code == ERET) ? epc : 32'h20;
    sb.push_back(e);
  endtask

  task automatic drive(
    input logic [31:0] flags,
    input logic        valid,
    input logic [31:0] pc,
    input logic        bd,
    input logic [31:0] status,
    input logic [31:0] cause,
    input logic [31:0] epc
  );
    bus.excepttype_i        = flags;
    bus.inst_valid_i        = valid;
    bus.current_inst_addr_i = pc;
    bus.is_in_delayslot_i   = bd;
    bus.cp0_status_i        = status;
    bus.cp0_cause_i         = cause;
    bus.cp0_epc_i           = epc;
  endtask

  // Garbage inputs after acceptance prove the snapshot is used.
  task automatic scramble();
    drive(32'h0, 1'b0, 32'hBAD0_0BAD, 1'b1,
          32'hFFFF_FF0C, 32'h0, 32'hDEAD_BEEF);
  endtask

  task automatic drain();
    int k = 0;
    while (sb.size() > 0 && k < 20) begin
      @(posedge clk);
      k++;
    end
    #1;
    tests++;
    assert (sb.size() == 0) else begin
      fails++;
      $error("FAIL %s drain timeout left=%0d exp=0",
             cur_tag, sb.size());
      sb.delete();
    end
  endtask

  task automatic one_event(
    input string       tag,
    input logic [31:0] flags,
    input logic [31:0] pc,
    input logic        bd,
    input logic [31:0] status,
    input logic [31:0] cause,
    input logic [31:0] epc,
    input logic [4:0]  code
  );
    @(posedge clk); #1;
    cur_tag = tag;
    drive(flags, 1'b1, pc, bd, status, cause, epc);
    push_idle(1);
    push_seq(code, pc, bd, status, epc);
    push_idle(2);
    @(posedge clk); #1;
    scramble();
    drain();
  endtask

  task automatic check_zero(input string tag);
    obs_t got;
    got = sample();
    tests++;
    assert (got === obs_t'(0)) else begin
      fails++;
      $error("FAIL %s got=%h exp=0", tag, got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive('0, 1'b0, '0, 1'b0, '0, '0, '0);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    one_event("syscall", 32'h100, 32'h100, 1'b0,
              32'h1000_0001, 32'h0, 32'h0, 5'h08);
    one_event("ovf_dslot", 32'h800, 32'h204, 1'b1,
              32'h1000_0001, 32'h0, 32'h0, 5'h0C);
    one_event("eret", 32'h1000, 32'h300, 1'b0,
              32'h1000_0003, 32'h0, 32'h400, ERET);
    one_event("irq_wins", 32'h100, 32'h600, 1'b0,
              32'h0000_0401, 32'h400, 32'h0, 5'h00);
    one_event("irq_exl", 32'h100, 32'h604, 1'b0,
              32'h0000_0403, 32'h400, 32'h0, 5'h08);
    one_event("irq_ie0", 32'h200, 32'h608, 1'b0,
              32'h0000_0400, 32'h400, 32'h0, 5'h0A);
    one_event("ri_over_tr", 32'hE00, 32'h700, 1'b0,
              32'h1, 32'h0, 32'h0, 5'h0A);
    one_event("tr_over_ov", 32'h1C00, 32'h704, 1'b0,
              32'h1, 32'h0, 32'h0, 5'h0D);
    one_event("pc_wrap", 32'h100, 32'h0, 1'b1,
              32'h1, 32'h0, 32'h0, 5'h08);

    // Flags without a valid instruction must be ignored.
    @(posedge clk); #1;
    cur_tag = "no_valid";
    drive(32'h1F00, 1'b0, 32'h800, 1'b0,
          32'h0000_0401, 32'h400, 32'h0);
    push_idle(4);
    drain();

    // Second syscall arrives in WR_STATUS: one flush only.
    @(posedge clk); #1;
    cur_tag = "busy_ignore";
    drive(32'h100, 1'b1, 32'h900, 1'b0,
          32'h1, 32'h0, 32'h0);
    push_idle(1);
    push_seq(5'h08, 32'h900, 1'b0, 32'h1, 32'h0);
    push_idle(4);
    @(posedge clk); #1;
    scramble();
    @(posedge clk); #1;
    drive(32'h100, 1'b1, 32'hA00, 1'b0,
          32'h1, 32'h0, 32'h0);
    @(posedge clk); #1;
    scramble();
    drain();

    // Reset while in WR_EPC.
    @(posedge clk); #1;
    cur_tag = "rst_mid";
    drive(32'h100, 1'b1, 32'hB00, 1'b0,
          32'h1, 32'h0, 32'h0);
    push_idle(1);
    begin
      obs_t e;
      e = '0;
      e.stall = 1'b1; e.we = 1'b1;
      e.waddr = 5'd14; e.data = 32'hB00;
      e.cause_we = 1'b1; e.excode = 5'h08;
      e.exct = 5'h08;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    scramble();
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 check_zero("rst_async");
    @(posedge clk); #1;
    check_zero("rst_hold");
    @(negedge clk); #1;
    rst_n = 1'b1;
    push_idle(5);
    drain();

    one_event("after_rst", 32'h800, 32'hC04, 1'b0,
              32'h1000_0001, 32'h0, 32'h0, 5'h0C);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
